alu_exec_stage: RTL and testbench

ALU_EXEC_STAGE -- requirements
Module: alu_exec_stage

---
 rtl/alu_exec_if.sv | 26 ++
 rtl/alu_exec_stage.sv | 177 +++++++++++++++++
 tb/tb_alu_exec_stage.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/alu_exec_if.sv
// Operation/result handshake bundle for the ALU execute stage.
// master = upstream/downstream side, slave = the stage itself.
interface alu_exec_if;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  alu_cont;
  logic [4:0]  flag_en;
  logic [3:0]  cond;
  logic [15:0] dst;
  logic [15:0] src;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic [4:0]  flags;
  logic        busy;

  modport master (
    output in_valid, alu_cont, flag_en, cond, dst, src, out_ready,
    input  in_ready, out_valid, result, flags, busy
  );

  modport slave (
    input  in_valid, alu_cont, flag_en, cond, dst, src, out_ready,
    output in_ready, out_valid, result, flags, busy
  );
endinterface

// File: rtl/alu_exec_stage.sv
// Single-issue ALU execute stage: 1-cycle ops, 16-cycle shift-add multiply, registered result.
// Accepts only when IDLE and the result register is empty or being drained this cycle.
module alu_exec_stage (
  input  logic       clk,
  input  logic       reset,
  alu_exec_if.slave  bus
);
  localparam logic [4:0] OP_ADD = 5'b00000, OP_SUB = 5'b00001, OP_MUL = 5'b00010,
                         OP_AND = 5'b00011, OP_OR = 5'b00100, OP_XOR = 5'b00101,
                         OP_NOT = 5'b00110, OP_SCOND = 5'b00111, OP_MOV = 5'b01000,
                         OP_LUI = 5'b01001, OP_NAND = 5'b01010, OP_LSH = 5'b01011,
                         OP_LSL = 5'b01100, OP_LSR = 5'b01101, OP_ASHU = 5'b01110,
                         OP_ASR = 5'b01111, OP_BCOND = 5'b10000, OP_JCOND = 5'b10001;

  typedef enum logic {S_IDLE, S_MUL} state_t;
  state_t r_state, w_state_nxt;

  logic [3:0]  r_cnt;
  logic [15:0] r_mcand, r_mplier, r_acc, r_result;
  logic [4:0]  r_flags, r_mul_fen;
  logic        r_out_valid;

  logic        w_in_ready, w_accept, w_consume, w_is_mul, w_cond_true, w_flag_wr;
  logic [16:0] w_sum, w_diff;
  logic [15:0] w_res, w_acc_nxt;
  logic [4:0]  w_neg_amt, w_flags_new;
  logic        w_c, w_l, w_f, w_n;

  function automatic logic [15:0] f_shl(input logic [15:0] d, input logic [4:0] m);
    return m[4] ? 16'h0000 : (d << m[3:0]);
  endfunction

  // Magnitudes of 16 and above flush to zero, or to all-sign for arithmetic shifts.
  function automatic logic [15:0] f_shr(input logic [15:0] d, input logic [4:0] m, input logic arith);
    logic [15:0] fill;
    fill = {16{arith & d[15]}};
    if (m[4]) return fill;
    return (d >> m[3:0]) | ((~(16'hFFFF >> m[3:0])) & fill);
  endfunction

  function automatic logic [4:0] f_merge(input logic [4:0] en, input logic [4:0] nw, input logic [4:0] old);
    return (en & nw) | (~en & old);
  endfunction

  assign w_consume  = r_out_valid && bus.out_ready;
  assign w_in_ready = !reset && (r_state == S_IDLE) && (!r_out_valid || bus.out_ready);
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_is_mul   = (bus.alu_cont == OP_MUL);
  assign w_sum      = {1'b0, bus.dst} + {1'b0, bus.src};
  assign w_diff     = {1'b0, bus.dst} - {1'b0, bus.src};
  assign w_neg_amt  = 5'd0 - bus.src[4:0];
  assign w_acc_nxt  = r_acc + (r_mplier[r_cnt] ? (r_mcand << r_cnt) : 16'h0000);

  // Flag register order is C,L,F,Z,N from bit 4 down to bit 0.
  always_comb begin
    w_cond_true = 1'b0;
    case (bus.cond)
      4'h0: w_cond_true = r_flags[1];
      4'h1: w_cond_true = !r_flags[1];
      4'h2: w_cond_true = r_flags[4];
      4'h3: w_cond_true = !r_flags[4];
      4'h4: w_cond_true = r_flags[3];
      4'h5: w_cond_true = !r_flags[3];
      4'h6: w_cond_true = r_flags[0];
      4'h7: w_cond_true = !r_flags[0];
      4'h8: w_cond_true = r_flags[2];
      4'h9: w_cond_true = !r_flags[2];
      4'hA: w_cond_true = !r_flags[3] && !r_flags[1];
      4'hB: w_cond_true = r_flags[3] || r_flags[1];
      4'hC: w_cond_true = !r_flags[0] && !r_flags[1];
      4'hD: w_cond_true = r_flags[0] || r_flags[1];
      4'hE: w_cond_true = 1'b1;
      default: w_cond_true = 1'b0;
    endcase
  end

  always_comb begin
    w_res     = 16'h0000;
    w_c       = 1'b0;
    w_l       = 1'b0;
    w_f       = 1'b0;
    w_n       = 1'b0;
    w_flag_wr = 1'b1;
    case (bus.alu_cont)
      OP_ADD: begin
        w_res = w_sum[15:0];
        w_c   = w_sum[16];
        w_f   = (bus.dst[15] == bus.src[15]) && (w_sum[15] != bus.dst[15]);
        w_l   = bus.dst < bus.src;
        w_n   = $signed(bus.dst) < $signed(bus.src);
      end
      OP_SUB: begin
        w_res = w_diff[15:0];
        w_c   = w_diff[16];
        w_f   = (bus.dst[15] != bus.src[15]) && (w_diff[15] != bus.dst[15]);
        w_l   = bus.dst < bus.src;
        w_n   = $signed(bus.dst) < $signed(bus.src);
      end
      OP_AND:   w_res = bus.dst & bus.src;
      OP_OR:    w_res = bus.dst | bus.src;
      OP_XOR:   w_res = bus.dst ^ bus.src;
      OP_NOT:   w_res = ~bus.dst;
      OP_NAND:  w_res = ~(bus.dst & bus.src);
      OP_MOV:   w_res = bus.src;
      OP_LUI:   w_res = {bus.dst[7:0], bus.src[7:0]};
      OP_SCOND: w_res = {15'b0, w_cond_true};
      OP_LSL:   w_res = f_shl(bus.dst, bus.src[4:0]);
      OP_LSR:   w_res = f_shr(bus.dst, w_neg_amt, 1'b0);
      OP_ASR:   w_res = f_shr(bus.dst, w_neg_amt, 1'b1);
      OP_LSH:   w_res = bus.src[4] ? f_shr(bus.dst, w_neg_amt, 1'b0) : f_shl(bus.dst, bus.src[4:0]);
      OP_ASHU:  w_res = bus.src[4] ? f_shr(bus.dst, w_neg_amt, 1'b1) : f_shl(bus.dst, bus.src[4:0]);
      OP_BCOND: w_res = w_cond_true ? w_sum[15:0] : bus.dst;
      OP_JCOND: w_res = w_cond_true ? bus.src : bus.dst;
      OP_MUL:   w_res = 16'h0000;
      default:  w_flag_wr = 1'b0;
    endcase
  end

  assign w_flags_new = {w_c, w_l, w_f, (w_res == 16'h0000), w_n};

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept && w_is_mul) w_state_nxt = S_MUL;
      S_MUL:  if (r_cnt == 4'd15) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt       <= 4'd0;
      r_mcand     <= 16'h0000;
      r_mplier    <= 16'h0000;
      r_acc       <= 16'h0000;
      r_result    <= 16'h0000;
      r_flags     <= 5'b00000;
      r_mul_fen   <= 5'b00000;
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      if (w_is_mul) begin
        r_mcand     <= bus.dst;
        r_mplier    <= bus.src;
        r_acc       <= 16'h0000;
        r_cnt       <= 4'd0;
        r_mul_fen   <= bus.flag_en;
        r_out_valid <= 1'b0;
      end else begin
        r_result    <= w_res;
        r_out_valid <= 1'b1;
        if (w_flag_wr) r_flags <= f_merge(bus.flag_en, w_flags_new, r_flags);
      end
    end else begin
      if (w_consume) r_out_valid <= 1'b0;
      if (r_state == S_MUL) begin
        r_acc <= w_acc_nxt;
        r_cnt <= r_cnt + 4'd1;
        if (r_cnt == 4'd15) begin
          r_result    <= w_acc_nxt;
          r_out_valid <= 1'b1;
          r_flags     <= f_merge(r_mul_fen, {3'b000, (w_acc_nxt == 16'h0000), 1'b0}, r_flags);
        end
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;
  assign bus.flags     = r_flags;
  assign bus.busy      = (r_state == S_MUL);
endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed table-driven bench for alu_exec_stage plus multiply, backpressure and reset sequences.
module tb_alu_exec_stage;
  logic clk = 1'b0;
  logic reset = 1'b1;
  alu_exec_if bus();

  alu_exec_stage dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [4:0]  op;
    logic [4:0]  fen;
    logic [3:0]  cond;
    logic [15:0] dst;
    logic [15:0] src;
    logic [15:0] exp_res;
    logic [4:0]  exp_flags;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] op, input logic [4:0] fen, input logic [3:0] c,
                       input logic [15:0] d, input logic [15:0] s);
    bus.in_valid = v;
    bus.alu_cont = op;
    bus.flag_en  = fen;
    bus.cond     = c;
    bus.dst      = d;
    bus.src      = s;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int bad;
    int seen;
    //          op      fen       cond  dst      src      result   flags CLFZN
    vecs.push_back('{5'h00, 5'h1F, 4'h0, 16'h7FFF, 16'h0001, 16'h8000, 5'b00100});
    vecs.push_back('{5'h00, 5'h1F, 4'h0, 16'hFFFF, 16'h0001, 16'h0000, 5'b10011});
    vecs.push_back('{5'h01, 5'h1F, 4'h0, 16'h0003, 16'h0005, 16'hFFFE, 5'b11001});
    vecs.push_back('{5'h12, 5'h1F, 4'h0, 16'h0001, 16'h0001, 16'h0000, 5'b11001});
    vecs.push_back('{5'h01, 5'h1F, 4'h0, 16'h8000, 16'h0001, 16'h7FFF, 5'b00101});
    vecs.push_back('{5'h07, 5'h00, 4'h8, 16'h0000, 16'h0000, 16'h0001, 5'b00101});
    vecs.push_back('{5'h07, 5'h00, 4'hC, 16'h0000, 16'h0000, 16'h0000, 5'b00101});
    vecs.push_back('{5'h10, 5'h00, 4'h6, 16'h0010, 16'h0020, 16'h0030, 5'b00101});
    vecs.push_back('{5'h11, 5'h00, 4'h2, 16'h1111, 16'h2222, 16'h1111, 5'b00101});
    vecs.push_back('{5'h11, 5'h00, 4'hE, 16'h1111, 16'h2222, 16'h2222, 5'b00101});
    vecs.push_back('{5'h01, 5'h0B, 4'h0, 16'h0005, 16'h0005, 16'h0000, 5'b00110});
    vecs.push_back('{5'h07, 5'h00, 4'h0, 16'h0000, 16'h0000, 16'h0001, 5'b00110});
    vecs.push_back('{5'h07, 5'h00, 4'hF, 16'h0000, 16'h0000, 16'h0000, 5'b00110});
    vecs.push_back('{5'h03, 5'h1F, 4'h0, 16'hF0F0, 16'h3C3C, 16'h3030, 5'b00000});
    vecs.push_back('{5'h05, 5'h1F, 4'h0, 16'hAAAA, 16'hAAAA, 16'h0000, 5'b00010});
    vecs.push_back('{5'h07, 5'h00, 4'hB, 16'h0000, 16'h0000, 16'h0001, 5'b00010});
    vecs.push_back('{5'h07, 5'h00, 4'hA, 16'h0000, 16'h0000, 16'h0000, 5'b00010});
    vecs.push_back('{5'h09, 5'h1F, 4'h0, 16'h0012, 16'h0034, 16'h1234, 5'b00000});
    vecs.push_back('{5'h08, 5'h1F, 4'h0, 16'h0000, 16'hBEEF, 16'hBEEF, 5'b00000});
    vecs.push_back('{5'h0C, 5'h1F, 4'h0, 16'h0001, 16'h000F, 16'h8000, 5'b00000});
    vecs.push_back('{5'h0D, 5'h1F, 4'h0, 16'h8000, 16'h001F, 16'h4000, 5'b00000});
    vecs.push_back('{5'h0F, 5'h1F, 4'h0, 16'h8000, 16'h001F, 16'hC000, 5'b00000});
    vecs.push_back('{5'h0E, 5'h1F, 4'h0, 16'h8000, 16'h001C, 16'hF800, 5'b00000});
    vecs.push_back('{5'h0B, 5'h1F, 4'h0, 16'h8000, 16'h001C, 16'h0800, 5'b00000});
    vecs.push_back('{5'h0B, 5'h1F, 4'h0, 16'h8000, 16'h0010, 16'h0000, 5'b00010});
    vecs.push_back('{5'h0E, 5'h1F, 4'h0, 16'h8000, 16'h0010, 16'hFFFF, 5'b00000});
    vecs.push_back('{5'h0B, 5'h1F, 4'h0, 16'h00FF, 16'h0004, 16'h0FF0, 5'b00000});

    drive(1'b0, 5'h00, 5'h00, 4'h0, 16'h0000, 16'h0000);
    bus.out_ready = 1'b1;
    #12;
    chk("reset_out_valid", {15'b0, bus.out_valid}, 16'h0000);
    chk("reset_result", bus.result, 16'h0000);
    chk("reset_flags", {11'b0, bus.flags}, 16'h0000);
    chk("reset_busy", {15'b0, bus.busy}, 16'h0000);
    chk("reset_in_ready", {15'b0, bus.in_ready}, 16'h0000);
    @(posedge clk);
    #1 reset = 1'b0;
    #1 chk("post_reset_in_ready", {15'b0, bus.in_ready}, 16'h0001);

    foreach (vecs[i]) begin
      drive(1'b1, vecs[i].op, vecs[i].fen, vecs[i].cond, vecs[i].dst, vecs[i].src);
      tick();
      chk($sformatf("vec%0d_result", i), bus.result, vecs[i].exp_res);
      chk($sformatf("vec%0d_flags", i), {11'b0, bus.flags}, {11'b0, vecs[i].exp_flags});
      chk($sformatf("vec%0d_out_valid", i), {15'b0, bus.out_valid}, 16'h0001);
    end
    drive(1'b0, 5'h00, 5'h00, 4'h0, 16'h0000, 16'h0000);
    tick();
    chk("drain_out_valid", {15'b0, bus.out_valid}, 16'h0000);

    // Multiply with a held add waiting upstream and the consumer stalled at completion.
    drive(1'b1, 5'h02, 5'h1F, 4'h0, 16'h0123, 16'h0011);
    tick();
    drive(1'b1, 5'h00, 5'h1F, 4'h0, 16'h0001, 16'h0002);
    bus.out_ready = 1'b0;
    bad = 0;
    for (int k = 1; k <= 15; k++) begin
      if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) bad++;
      tick();
    end
    if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) bad++;
    chk("mul_busy_cycles_bad", bad[15:0], 16'h0000);
    tick();
    chk("mul_out_valid_at_16", {15'b0, bus.out_valid}, 16'h0001);
    chk("mul_result", bus.result, 16'h1353);
    chk("mul_busy_done", {15'b0, bus.busy}, 16'h0000);

    bad = 0;
    for (int k = 0; k < 3; k++) begin
      if (bus.in_ready !== 1'b0) bad++;
      tick();
      if (bus.result !== 16'h1353 || bus.flags !== 5'b00000 || bus.out_valid !== 1'b1) bad++;
    end
    chk("stall_hold_bad", bad[15:0], 16'h0000);
    bus.out_ready = 1'b1;
    #1 chk("stall_release_in_ready", {15'b0, bus.in_ready}, 16'h0001);
    tick();
    chk("b2b_out_valid", {15'b0, bus.out_valid}, 16'h0001);
    chk("b2b_result", bus.result, 16'h0003);
    chk("b2b_flags", {11'b0, bus.flags}, 16'h0009);
    drive(1'b0, 5'h00, 5'h00, 4'h0, 16'h0000, 16'h0000);
    tick();
    chk("b2b_drain", {15'b0, bus.out_valid}, 16'h0000);

    // Reset in the middle of a multiply.
    drive(1'b1, 5'h02, 5'h1F, 4'h0, 16'h0123, 16'h0011);
    tick();
    drive(1'b0, 5'h00, 5'h00, 4'h0, 16'h0000, 16'h0000);
    for (int k = 0; k < 8; k++) tick();
    reset = 1'b1;
    #1;
    chk("midmul_rst_busy", {15'b0, bus.busy}, 16'h0000);
    chk("midmul_rst_out_valid", {15'b0, bus.out_valid}, 16'h0000);
    chk("midmul_rst_result", bus.result, 16'h0000);
    chk("midmul_rst_flags", {11'b0, bus.flags}, 16'h0000);
    chk("midmul_rst_in_ready", {15'b0, bus.in_ready}, 16'h0000);
    tick();
    reset = 1'b0;
    bus.out_ready = 1'b0;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) seen++;
    end
    chk("midmul_no_stale", seen[15:0], 16'h0000);
    bus.out_ready = 1'b1;
    drive(1'b1, 5'h00, 5'h1F, 4'h0, 16'h0002, 16'h0003);
    tick();
    drive(1'b0, 5'h00, 5'h00, 4'h0, 16'h0000, 16'h0000);
    chk("after_rst_add_valid", {15'b0, bus.out_valid}, 16'h0001);
    chk("after_rst_add_result", bus.result, 16'h0005);
    chk("after_rst_add_flags", {11'b0, bus.flags}, 16'h0009);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
